// File: rtl/irq_controller_pkg.sv
// Shared constants for the Processor12 interrupt controller: source count,
// VECTOR layout and register offsets within the 16-word window.
package irq_controller_pkg;

  localparam int unsigned NUM_IRQ          = 24;
  localparam int unsigned VECTOR_VALID_BIT = 11;

  typedef enum logic [3:0] {
    IRQ_PEND_L = 4'd0,
    IRQ_PEND_H = 4'd1,
    IRQ_EN_L   = 4'd2,
    IRQ_EN_H   = 4'd3,
    IRQ_MODE_L = 4'd4,
    IRQ_MODE_H = 4'd5,
    IRQ_CLR_L  = 4'd6,
    IRQ_CLR_H  = 4'd7,
    IRQ_SET_L  = 4'd8,
    IRQ_SET_H  = 4'd9,
    IRQ_VECTOR = 4'd10
  } reg_off_e;

endpackage

// File: rtl/irq_priority_enc.sv
// Combinational priority encoder over the active irq lines.
// Bit 0 has the highest priority.
module irq_priority_enc
  import irq_controller_pkg::*;
(
  input  logic [23:0] irq_in,
  output logic [4:0]  idx,
  output logic        valid
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (irq_in[i] && !found) begin
        idx   = 5'(i);
        found = 1'b1;
      end
    end
  end

  assign valid = |irq_in;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped 24-source interrupt controller for the Processor12 bus.
// Zero-wait target: reads are combinational, writes commit on the closing edge.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR       = 24'o77777700,
  parameter logic        SRC_RESET_LEVEL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] address,
  input  logic [11:0] data_in,
  input  logic        mem_write,
  output logic [11:0] data_out,
  output logic        sel,
  input  logic [23:0] src,
  output logic [23:0] irq,
  output logic        irq_any
);

  logic [23:0] s1_q, s1_d, s2_q, s2_d, h_q, h_d;
  logic [23:0] pending_q, pending_d;
  logic [23:0] enable_q, enable_d;
  logic [23:0] mode_q, mode_d;
  logic [23:0] clr, swset, edge_ev, set_ev;
  logic [3:0]  off;
  logic        wr_en;
  logic [4:0]  vec_idx;
  logic        vec_valid;
  logic [11:0] vector;

  assign sel   = (address[23:4] == BASE_ADDR[23:4]);
  assign off   = address[3:0];
  assign wr_en = mem_write & sel;

  always_comb begin
    s1_d     = src;
    s2_d     = s1_q;
    h_d      = s2_q;
    enable_d = enable_q;
    mode_d   = mode_q;
    clr      = '0;
    swset    = '0;
    if (wr_en) begin
      case (off)
        IRQ_EN_L:   enable_d[11:0]  = data_in;
        IRQ_EN_H:   enable_d[23:12] = data_in;
        IRQ_MODE_L: mode_d[11:0]    = data_in;
        IRQ_MODE_H: mode_d[23:12]   = data_in;
        IRQ_CLR_L:  clr[11:0]       = data_in;
        IRQ_CLR_H:  clr[23:12]      = data_in;
        IRQ_SET_L:  swset[11:0]     = data_in;
        IRQ_SET_H:  swset[23:12]    = data_in;
        default:    ;
      endcase
    end
    // Set wins over clear so an event landing with a CLR write is not lost.
    edge_ev   = s2_q & ~h_q;
    set_ev    = (mode_q & edge_ev) | (~mode_q & s2_q) | swset;
    pending_d = set_ev | (pending_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q      <= {NUM_IRQ{SRC_RESET_LEVEL}};
      s2_q      <= {NUM_IRQ{SRC_RESET_LEVEL}};
      h_q       <= {NUM_IRQ{SRC_RESET_LEVEL}};
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      h_q       <= h_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
    end
  end

  assign irq     = pending_q & enable_q;
  assign irq_any = |irq;

  irq_priority_enc u_prio (
    .irq_in (irq),
    .idx    (vec_idx),
    .valid  (vec_valid)
  );

  always_comb begin
    vector                   = '0;
    vector[VECTOR_VALID_BIT] = vec_valid;
    vector[4:0]              = vec_idx;
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      case (off)
        IRQ_PEND_L: data_out = pending_q[11:0];
        IRQ_PEND_H: data_out = pending_q[23:12];
        IRQ_EN_L:   data_out = enable_q[11:0];
        IRQ_EN_H:   data_out = enable_q[23:12];
        IRQ_MODE_L: data_out = mode_q[11:0];
        IRQ_MODE_H: data_out = mode_q[23:12];
        IRQ_VECTOR: data_out = vector;
        default:    data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller.
module tb_irq_controller;
  import irq_controller_pkg::*;

  localparam logic [23:0] BASE = 24'o77777700;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] address = '0;
  logic [11:0] data_in = '0;
  logic        mem_write = 1'b0;
  logic [11:0] data_out;
  logic        sel;
  logic [23:0] src = '0;
  logic [23:0] irq;
  logic        irq_any;

  int checks = 0;
  int errors = 0;
  logic [11:0] rdv;

  irq_controller #(.BASE_ADDR(24'o77777700), .SRC_RESET_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in),
    .mem_write(mem_write), .data_out(data_out), .sel(sel),
    .src(src), .irq(irq), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [11:0] val);
    address = BASE + 24'(off);
    data_in = val;
    mem_write = 1'b1;
    @(posedge clk);
    #1 mem_write = 1'b0;
    address = '0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [11:0] val);
    address = BASE + 24'(off);
    mem_write = 1'b0;
    #1 val = data_out;
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    src = '0;
    do_reset();
    for (int unsigned o = 0; o < 16; o++) begin
      bus_read(4'(o), rdv);
      checks++;
      if (rdv !== 12'o0000) begin
        errors++;
        $display("FAIL reset_read off=%0d got %o exp 0000", o, rdv);
      end
    end
    checks++;
    if (irq !== 24'h0 || irq_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got irq=%h any=%b exp 0/0", irq, irq_any);
    end
    address = BASE - 24'd1; #1;
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL sel_below got %b exp 0", sel); end
    address = BASE; #1;
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL sel_base got %b exp 1", sel); end
    address = BASE + 24'd15; #1;
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL sel_top got %b exp 1", sel); end
    address = BASE + 24'd16; #1;
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL sel_above got %b exp 0", sel); end
    checks++; if (data_out !== 12'o0000) begin errors++; $display("FAIL dout_unsel got %o exp 0000", data_out); end
    address = '0;
  endtask

  task automatic test_edge();
    do_reset();
    bus_write(IRQ_EN_L, 12'o0001);
    bus_write(IRQ_MODE_L, 12'o0001);
    bus_read(IRQ_EN_L, rdv);
    checks++; if (rdv !== 12'o0001) begin errors++; $display("FAIL en_l_readback got %o exp 0001", rdv); end
    src[0] = 1'b1;
    @(posedge clk);
    #1 src[0] = 1'b0;
    cycles(1);
    checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL edge_latency_early got %b exp 0", irq[0]); end
    cycles(1);
    checks++; if (irq[0] !== 1'b1 || irq_any !== 1'b1) begin
      errors++; $display("FAIL edge_latency got irq0=%b any=%b exp 1/1", irq[0], irq_any);
    end
    bus_read(IRQ_VECTOR, rdv);
    checks++; if (rdv !== 12'o4000) begin errors++; $display("FAIL edge_vector got %o exp 4000", rdv); end
    bus_write(IRQ_CLR_L, 12'o0001);
    checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL edge_clear got %b exp 0", irq[0]); end
    cycles(3);
    checks++; if (irq !== 24'h0) begin errors++; $display("FAIL edge_no_retrigger got %h exp 0", irq); end
  endtask

  task automatic test_level();
    do_reset();
    src[13] = 1'b1;
    bus_write(IRQ_EN_H, 12'o0002);
    cycles(4);
    bus_read(IRQ_PEND_H, rdv);
    checks++; if (rdv !== 12'o0002) begin errors++; $display("FAIL level_pend got %o exp 0002", rdv); end
    checks++; if (irq !== 24'h002000) begin errors++; $display("FAIL level_irq got %h exp 002000", irq); end
    bus_write(IRQ_CLR_H, 12'o0002);
    bus_read(IRQ_PEND_H, rdv);
    checks++; if (rdv !== 12'o0002) begin errors++; $display("FAIL level_clr_held got %o exp 0002", rdv); end
    src[13] = 1'b0;
    cycles(3);
    bus_write(IRQ_CLR_H, 12'o0002);
    bus_read(IRQ_PEND_H, rdv);
    checks++; if (rdv !== 12'o0000) begin errors++; $display("FAIL level_clr_dropped got %o exp 0000", rdv); end
  endtask

  task automatic test_set_vs_clear();
    do_reset();
    bus_write(IRQ_EN_L, 12'o0040);
    bus_write(IRQ_MODE_L, 12'o0040);
    src[5] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus_write(IRQ_CLR_L, 12'o0040);
    bus_read(IRQ_PEND_L, rdv);
    checks++; if (rdv !== 12'o0040) begin errors++; $display("FAIL set_beats_clr got %o exp 0040", rdv); end
    bus_write(IRQ_CLR_L, 12'o0040);
    bus_read(IRQ_PEND_L, rdv);
    checks++; if (rdv !== 12'o0000) begin errors++; $display("FAIL edge_held_clr got %o exp 0000", rdv); end
    src[5] = 1'b0;
  endtask

  task automatic test_priority();
    do_reset();
    bus_write(IRQ_EN_L, 12'o7777);
    bus_write(IRQ_EN_H, 12'o7777);
    bus_write(IRQ_PEND_L, 12'o7777);
    bus_read(IRQ_PEND_L, rdv);
    checks++; if (rdv !== 12'o0000) begin errors++; $display("FAIL pend_readonly got %o exp 0000", rdv); end
    bus_write(IRQ_SET_L, 12'o0300);
    bus_write(IRQ_SET_H, 12'o4000);
    bus_read(IRQ_SET_L, rdv);
    checks++; if (rdv !== 12'o0000) begin errors++; $display("FAIL set_reads_zero got %o exp 0000", rdv); end
    bus_read(IRQ_VECTOR, rdv);
    checks++; if (rdv !== 12'o4006) begin errors++; $display("FAIL vec_bit6 got %o exp 4006", rdv); end
    bus_write(IRQ_CLR_L, 12'o0300);
    bus_read(IRQ_VECTOR, rdv);
    checks++; if (rdv !== 12'o4027) begin errors++; $display("FAIL vec_bit23 got %o exp 4027", rdv); end
    bus_write(IRQ_CLR_H, 12'o4000);
    bus_read(IRQ_VECTOR, rdv);
    checks++; if (rdv !== 12'o0000 || irq_any !== 1'b0) begin
      errors++; $display("FAIL vec_empty got %o any=%b exp 0000/0", rdv, irq_any);
    end
  endtask

  task automatic test_read_side_effects_and_reset();
    do_reset();
    bus_write(IRQ_EN_L, 12'o0004);
    bus_write(IRQ_SET_L, 12'o0004);
    for (int unsigned k = 0; k < 4; k++) begin
      bus_read(IRQ_PEND_L, rdv);
      checks++; if (rdv !== 12'o0004) begin errors++; $display("FAIL reread_pend got %o exp 0004", rdv); end
      @(posedge clk);
      bus_read(IRQ_VECTOR, rdv);
      checks++; if (rdv !== 12'o4002) begin errors++; $display("FAIL reread_vec got %o exp 4002", rdv); end
      @(posedge clk);
      #1;
    end
    checks++; if (irq !== 24'h000004) begin errors++; $display("FAIL reread_irq got %h exp 000004", irq); end
    address = BASE + 24'(IRQ_SET_L);
    data_in = 12'o0010;
    mem_write = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1 mem_write = 1'b0;
    rst = 1'b1;
    checks++; if (irq !== 24'h0 || irq_any !== 1'b0) begin
      errors++; $display("FAIL midreset_irq got %h any=%b exp 0/0", irq, irq_any);
    end
    bus_read(IRQ_PEND_L, rdv);
    checks++; if (rdv !== 12'o0000) begin errors++; $display("FAIL midreset_pend got %o exp 0000", rdv); end
    bus_read(IRQ_EN_L, rdv);
    checks++; if (rdv !== 12'o0000) begin errors++; $display("FAIL midreset_en got %o exp 0000", rdv); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_set_vs_clear();
    test_priority();
    test_read_side_effects_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
